// File: rtl/hazard_if.sv
// hazard_if: bundle between the decode/pipeline control of the 5-stage core
// and the hazard sequencer.
//   master: the pipeline side. It drives the D-stage instruction fields and
//           E_branch_taken, and consumes the stall/flush/forward controls.
//   slave : the hazard sequencer. It consumes the D-stage fields and drives
//           the controls.
// Signals:
//   D_valid, D_rs1, D_rs2, D_use_rs1, D_use_rs2, D_rd, D_RegWrite,
//   D_MemRead, D_is_div           instruction currently in D
//   E_branch_taken                instruction in E resolved as a taken branch
//   pc_stall, FD_stall, FD_flush, DE_stall, DE_flush, EM_bubble
//                                 pipeline register controls
//   E_rs1_forward, E_rs2_forward  E-stage source comes from the M result
//   M_rs1_forward, M_rs2_forward  E-stage source comes from the W result
//   busy                          divider sequence is stalling the pipe
interface hazard_if #(
    parameter int REG_AW = 5
);
    logic              D_valid;
    logic [REG_AW-1:0] D_rs1;
    logic [REG_AW-1:0] D_rs2;
    logic              D_use_rs1;
    logic              D_use_rs2;
    logic [REG_AW-1:0] D_rd;
    logic              D_RegWrite;
    logic              D_MemRead;
    logic              D_is_div;
    logic              E_branch_taken;

    logic              pc_stall;
    logic              FD_stall;
    logic              FD_flush;
    logic              DE_stall;
    logic              DE_flush;
    logic              EM_bubble;
    logic              E_rs1_forward;
    logic              E_rs2_forward;
    logic              M_rs1_forward;
    logic              M_rs2_forward;
    logic              busy;

    modport master (
        output D_valid, D_rs1, D_rs2, D_use_rs1, D_use_rs2, D_rd,
               D_RegWrite, D_MemRead, D_is_div, E_branch_taken,
        input  pc_stall, FD_stall, FD_flush, DE_stall, DE_flush, EM_bubble,
               E_rs1_forward, E_rs2_forward, M_rs1_forward, M_rs2_forward,
               busy
    );

    modport slave (
        input  D_valid, D_rs1, D_rs2, D_use_rs1, D_use_rs2, D_rd,
               D_RegWrite, D_MemRead, D_is_div, E_branch_taken,
        output pc_stall, FD_stall, FD_flush, DE_stall, DE_flush, EM_bubble,
               E_rs1_forward, E_rs2_forward, M_rs1_forward, M_rs2_forward,
               busy
    );
endinterface

// File: rtl/hazard_sequencer.sv
// hazard_sequencer: hazard controller for the 5-stage core.
// It keeps a shadow copy of the destination information of the instructions
// in E and M. From that copy it registers the four forwarding flags for each
// instruction that enters E, and it sequences the load-use stall, the
// multi-cycle divide stall and the taken-branch flush.
// Ports:
//   clk  core clock
//   rst  asynchronous active-high reset
//   hz   hazard_if.slave: D-stage fields and branch in; controls out
// Stall/flush controls are combinational from state, shadows and D inputs.
// The forward flags are registered.
module hazard_sequencer #(
    parameter int DIV_LAT = 4,
    parameter int REG_AW  = 5
) (
    input  logic     clk,
    input  logic     rst,
    hazard_if.slave  hz
);
    localparam int              CNT_W    = $clog2(DIV_LAT);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_LAT - 2);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [REG_AW-1:0] REG_X0  = REG_AW'(0);

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_DIV_BUSY = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        ACT_ADVANCE  = 2'd0,
        ACT_FLUSH    = 2'd1,
        ACT_DIV_HOLD = 2'd2,
        ACT_LOAD_USE = 2'd3
    } action_t;

    // A source depends on a stage when it is really read, is not x0, and the
    // stage holds a valid register-writing instruction with the same rd.
    function automatic logic src_match(
        input logic              used,
        input logic [REG_AW-1:0] addr,
        input logic              v,
        input logic              we,
        input logic [REG_AW-1:0] rd
    );
        return used && (addr != REG_X0) && v && we && (rd == addr);
    endfunction

    state_t            state_r, state_nx_s;
    logic [CNT_W-1:0]  cnt_r, cnt_nx_s;
    action_t           action_s;

    logic              e_v_r, e_we_r, e_ld_r, e_div_r;
    logic [REG_AW-1:0] e_rd_r;
    logic              m_v_r, m_we_r;
    logic [REG_AW-1:0] m_rd_r;

    logic              e_rs1_fwd_r, e_rs2_fwd_r, m_rs1_fwd_r, m_rs2_fwd_r;

    logic              hit_e_rs1_s, hit_e_rs2_s, hit_m_rs1_s, hit_m_rs2_s;
    logic              load_use_s;

    logic              pc_stall_s, fd_stall_s, fd_flush_s;
    logic              de_stall_s, de_flush_s, em_bubble_s, busy_s;

    assign hit_e_rs1_s = src_match(hz.D_use_rs1, hz.D_rs1, e_v_r, e_we_r, e_rd_r);
    assign hit_e_rs2_s = src_match(hz.D_use_rs2, hz.D_rs2, e_v_r, e_we_r, e_rd_r);
    assign hit_m_rs1_s = src_match(hz.D_use_rs1, hz.D_rs1, m_v_r, m_we_r, m_rd_r);
    assign hit_m_rs2_s = src_match(hz.D_use_rs2, hz.D_rs2, m_v_r, m_we_r, m_rd_r);
    assign load_use_s  = hz.D_valid && e_v_r && e_ld_r && (hit_e_rs1_s || hit_e_rs2_s);

    // Choose the pipeline action for this cycle; branch is ignored once the
    // divider owns E because a divide cannot be a branch.
    always_comb begin
        action_s = ACT_ADVANCE;
        case (state_r)
            ST_RUN: begin
                if (hz.E_branch_taken) begin
                    action_s = ACT_FLUSH;
                end else if (e_v_r && e_div_r) begin
                    action_s = ACT_DIV_HOLD;
                end else if (load_use_s) begin
                    action_s = ACT_LOAD_USE;
                end else begin
                    action_s = ACT_ADVANCE;
                end
            end
            ST_DIV_BUSY: begin
                if (cnt_r != CNT_ZERO) begin
                    action_s = ACT_DIV_HOLD;
                end else begin
                    action_s = ACT_ADVANCE;
                end
            end
            default: action_s = ACT_ADVANCE;
        endcase
    end

    // FSM state and divide counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_RUN;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
        end
    end

    // FSM next state: the first hold cycle loads DIV_LAT-2 so that the
    // counter reaches zero on the divide's last E cycle.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        case (state_r)
            ST_RUN: begin
                if (action_s == ACT_DIV_HOLD) begin
                    state_nx_s = ST_DIV_BUSY;
                    cnt_nx_s   = CNT_LOAD;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_DIV_BUSY: begin
                if (cnt_r != CNT_ZERO) begin
                    cnt_nx_s = cnt_r - CNT_ONE;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            default: begin
                state_nx_s = ST_RUN;
                cnt_nx_s   = CNT_ZERO;
            end
        endcase
    end

    // FSM outputs: pipeline controls decoded from the chosen action. busy
    // covers exactly the cycles in which the divider is stalling the pipe.
    always_comb begin
        pc_stall_s  = 1'b0;
        fd_stall_s  = 1'b0;
        fd_flush_s  = 1'b0;
        de_stall_s  = 1'b0;
        de_flush_s  = 1'b0;
        em_bubble_s = 1'b0;
        busy_s      = 1'b0;
        case (action_s)
            ACT_FLUSH: begin
                fd_flush_s = 1'b1;
                de_flush_s = 1'b1;
            end
            ACT_DIV_HOLD: begin
                pc_stall_s  = 1'b1;
                fd_stall_s  = 1'b1;
                de_stall_s  = 1'b1;
                em_bubble_s = 1'b1;
                busy_s      = 1'b1;
            end
            ACT_LOAD_USE: begin
                pc_stall_s = 1'b1;
                fd_stall_s = 1'b1;
                de_flush_s = 1'b1;
            end
            default: begin
                pc_stall_s = 1'b0;
            end
        endcase
    end

    // Shadow pipeline and forward flags follow the chosen action.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_v_r       <= 1'b0;
            e_rd_r      <= REG_X0;
            e_we_r      <= 1'b0;
            e_ld_r      <= 1'b0;
            e_div_r     <= 1'b0;
            m_v_r       <= 1'b0;
            m_rd_r      <= REG_X0;
            m_we_r      <= 1'b0;
            e_rs1_fwd_r <= 1'b0;
            e_rs2_fwd_r <= 1'b0;
            m_rs1_fwd_r <= 1'b0;
            m_rs2_fwd_r <= 1'b0;
        end else begin
            case (action_s)
                ACT_ADVANCE: begin
                    e_v_r       <= hz.D_valid;
                    e_rd_r      <= hz.D_rd;
                    e_we_r      <= hz.D_RegWrite;
                    e_ld_r      <= hz.D_MemRead;
                    e_div_r     <= hz.D_is_div;
                    m_v_r       <= e_v_r;
                    m_rd_r      <= e_rd_r;
                    m_we_r      <= e_we_r;
                    // The younger producer (now in E) wins over the one in M.
                    e_rs1_fwd_r <= hz.D_valid && hit_e_rs1_s;
                    e_rs2_fwd_r <= hz.D_valid && hit_e_rs2_s;
                    m_rs1_fwd_r <= hz.D_valid && hit_m_rs1_s && !hit_e_rs1_s;
                    m_rs2_fwd_r <= hz.D_valid && hit_m_rs2_s && !hit_e_rs2_s;
                end
                ACT_DIV_HOLD: begin
                    m_v_r <= 1'b0;
                end
                default: begin
                    // FLUSH and LOAD_USE: bubble into E, E moves to M.
                    e_v_r       <= 1'b0;
                    e_we_r      <= 1'b0;
                    e_ld_r      <= 1'b0;
                    e_div_r     <= 1'b0;
                    m_v_r       <= e_v_r;
                    m_rd_r      <= e_rd_r;
                    m_we_r      <= e_we_r;
                    e_rs1_fwd_r <= 1'b0;
                    e_rs2_fwd_r <= 1'b0;
                    m_rs1_fwd_r <= 1'b0;
                    m_rs2_fwd_r <= 1'b0;
                end
            endcase
        end
    end

    assign hz.pc_stall      = pc_stall_s;
    assign hz.FD_stall      = fd_stall_s;
    assign hz.FD_flush      = fd_flush_s;
    assign hz.DE_stall      = de_stall_s;
    assign hz.DE_flush      = de_flush_s;
    assign hz.EM_bubble     = em_bubble_s;
    assign hz.busy          = busy_s;
    assign hz.E_rs1_forward = e_rs1_fwd_r;
    assign hz.E_rs2_forward = e_rs2_fwd_r;
    assign hz.M_rs1_forward = m_rs1_fwd_r;
    assign hz.M_rs2_forward = m_rs2_fwd_r;
endmodule
